tile_palette_ram: RTL and testbench

TILE_PALETTE_RAM -- requirements
Module: tile_palette_ram

---
 rtl/tile_palette_ram.sv | 158 +++++++++++++++
 tb/tb_tile_palette_ram.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_palette_ram.sv
// Double-buffered RGB palette: lookups read the active bank, writes fill the shadow bank.
// Banks swap at a frame boundary; reset re-initialises both banks to DEFAULT_COLOR.
module tile_palette_ram #(
  parameter int                   INDEX_W       = 5,
  parameter int                   COLOR_W       = 4,
  parameter logic [3*COLOR_W-1:0] DEFAULT_COLOR = 12'h48E,
  parameter int                   TRANSP_EN     = 1,
  parameter int                   TRANSP_INDEX  = 0
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   pix_valid_i,
  input  logic [INDEX_W-1:0]     pix_index_i,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic                   pix_valid_o,
  output logic                   pix_transp_o,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [INDEX_W-1:0]     wr_addr,
  input  logic [3*COLOR_W-1:0]   wr_data,
  input  logic                   swap_req,
  input  logic                   frame_start,
  output logic                   swap_pending,
  output logic                   init_busy
);

  localparam int DEPTH = 2**INDEX_W;
  localparam int EW    = 3*COLOR_W;
  localparam logic [INDEX_W-1:0] LAST = INDEX_W'(DEPTH-1);
  localparam logic [INDEX_W-1:0] TIDX = INDEX_W'(TRANSP_INDEX);

  typedef enum logic {
    IDLE = 1'b0,
    INIT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [INDEX_W-1:0]   init_addr_q, init_addr_d;
  logic                 bank_q, bank_d;
  logic                 pend_q, pend_d;
  logic                 swap_apply;

  logic                 s1_valid_q, s1_valid_d;
  logic [INDEX_W-1:0]   s1_index_q, s1_index_d;
  logic                 s1_bank_q, s1_bank_d;
  logic                 s1_init_q, s1_init_d;

  logic                 s2_valid_q, s2_valid_d;
  logic [EW-1:0]        s2_color_q, s2_color_d;
  logic                 s2_transp_q, s2_transp_d;

  logic                 vo_q, vo_d;
  logic [EW-1:0]        color_q, color_d;
  logic                 transp_q, transp_d;

  logic [EW-1:0]        mem_q [0:1][0:DEPTH-1];

  assign init_busy = (state_q == INIT);
  assign wr_ready  = !init_busy;

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    bank_d      = bank_q;
    pend_d      = pend_q;
    swap_apply  = 1'b0;
    if (state_q == INIT) begin
      init_addr_d = init_addr_q + INDEX_W'(1);
      if (init_addr_q == LAST) begin
        state_d = IDLE;
      end
    end
    swap_apply = frame_start && pend_q && !init_busy;
    if (swap_apply) begin
      bank_d = ~bank_q;
    end
    // A fresh request wins over a clear, so a same-cycle request waits a frame
    if (swap_req) begin
      pend_d = 1'b1;
    end else if (swap_apply) begin
      pend_d = 1'b0;
    end
  end

  always_comb begin
    s1_valid_d  = pix_valid_i;
    s1_index_d  = pix_index_i;
    s1_bank_d   = bank_d;
    s1_init_d   = init_busy;
    s2_valid_d  = s1_valid_q;
    s2_color_d  = mem_q[s1_bank_q][s1_index_q];
    if (s1_init_q) begin
      s2_color_d = DEFAULT_COLOR;
    end
    s2_transp_d = (TRANSP_EN != 0) && (s1_index_q == TIDX);
    vo_d        = s2_valid_q;
    color_d     = color_q;
    transp_d    = transp_q;
    if (s2_valid_q) begin
      color_d  = s2_color_q;
      transp_d = s2_transp_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= INIT;
      init_addr_q <= '0;
      bank_q      <= 1'b0;
      pend_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_index_q  <= '0;
      s1_bank_q   <= 1'b0;
      s1_init_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_color_q  <= DEFAULT_COLOR;
      s2_transp_q <= 1'b0;
      vo_q        <= 1'b0;
      color_q     <= DEFAULT_COLOR;
      transp_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      bank_q      <= bank_d;
      pend_q      <= pend_d;
      s1_valid_q  <= s1_valid_d;
      s1_index_q  <= s1_index_d;
      s1_bank_q   <= s1_bank_d;
      s1_init_q   <= s1_init_d;
      s2_valid_q  <= s2_valid_d;
      s2_color_q  <= s2_color_d;
      s2_transp_q <= s2_transp_d;
      vo_q        <= vo_d;
      color_q     <= color_d;
      transp_q    <= transp_d;
    end
  end

  // Writes target the pre-swap shadow bank, i.e. the bank about to go active
  always_ff @(posedge Clk) begin
    if (init_busy) begin
      mem_q[0][init_addr_q] <= DEFAULT_COLOR;
      mem_q[1][init_addr_q] <= DEFAULT_COLOR;
    end else if (Reset_n && wr_valid) begin
      mem_q[~bank_q][wr_addr] <= wr_data;
    end
  end

  assign red          = color_q[EW-1 -: COLOR_W];
  assign green        = color_q[2*COLOR_W-1 -: COLOR_W];
  assign blue         = color_q[COLOR_W-1:0];
  assign pix_valid_o  = vo_q;
  assign pix_transp_o = transp_q;
  assign swap_pending = pend_q;

endmodule

// File: tb/tb_tile_palette_ram.sv
// Scoreboard bench for tile_palette_ram: a behavioural palette model
// pushes expected lookups, each test task pops and compares them.
module tb_tile_palette_ram;

  localparam logic [11:0] DEF = 12'h48E;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid_i = 1'b0;
  logic [4:0]  pix_index_i = '0;
  logic        wr_valid = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        swap_req = 1'b0;
  logic        frame_start = 1'b0;

  logic [3:0]  red, green, blue;
  logic        pix_valid_o, pix_transp_o;
  logic        wr_ready, swap_pending, init_busy;
  logic [3:0]  red2, green2, blue2;
  logic        pix_valid2, pix_transp2;
  logic        wr_ready2, swap_pending2, init_busy2;

  always #5 clk = ~clk;

  tile_palette_ram dut (
    .Clk(clk), .Reset_n(rst_n),
    .pix_valid_i(pix_valid_i), .pix_index_i(pix_index_i),
    .red(red), .green(green), .blue(blue),
    .pix_valid_o(pix_valid_o), .pix_transp_o(pix_transp_o),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .frame_start(frame_start),
    .swap_pending(swap_pending), .init_busy(init_busy)
  );

  tile_palette_ram #(.TRANSP_EN(0)) dut_nt (
    .Clk(clk), .Reset_n(rst_n),
    .pix_valid_i(pix_valid_i), .pix_index_i(pix_index_i),
    .red(red2), .green(green2), .blue(blue2),
    .pix_valid_o(pix_valid2), .pix_transp_o(pix_transp2),
    .wr_valid(wr_valid), .wr_ready(wr_ready2),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .frame_start(frame_start),
    .swap_pending(swap_pending2), .init_busy(init_busy2)
  );

  typedef struct {
    bit        pv;
    bit [4:0]  pi;
    bit        wv;
    bit [4:0]  wa;
    bit [11:0] wd;
    bit        sr;
    bit        fs;
  } stim_t;

  logic [11:0] mdl [0:1][0:31];
  bit          mact = 1'b0;
  bit          mpend = 1'b0;
  int          mcnt = 32;
  logic [12:0] exq [$];
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic stim_t mk(bit pv, bit [4:0] pi, bit wv,
                               bit [4:0] wa, bit [11:0] wd,
                               bit sr, bit fs);
    stim_t s;
    s.pv = pv; s.pi = pi; s.wv = wv; s.wa = wa;
    s.wd = wd; s.sr = sr; s.fs = fs;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    pix_valid_i = s.pv; pix_index_i = s.pi;
    wr_valid = s.wv; wr_addr = s.wa; wr_data = s.wd;
    swap_req = s.sr; frame_start = s.fs;
  endtask

  // Advance the model by what the DUT samples at this edge, then clock it
  task automatic tick();
    bit busy, ap;
    if (!rst_n) begin
      mcnt = 32; mact = 1'b0; mpend = 1'b0;
      exq.delete();
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < 32; a++) mdl[b][a] = DEF;
    end else begin
      busy = (mcnt > 0);
      if (wr_valid && !busy) mdl[!mact][wr_addr] = wr_data;
      ap = frame_start && mpend && !busy;
      if (ap) mact = !mact;
      if (swap_req) mpend = 1'b1;
      else if (ap) mpend = 1'b0;
      if (pix_valid_i)
        exq.push_back({pix_index_i == 5'd0,
                       busy ? DEF : mdl[mact][pix_index_i]});
      if (busy) mcnt--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int cnt, wrbad;
    logic [12:0] e;
    rst_n = 1'b0;
    repeat (3) tick();
    n_chk++;
    if ({init_busy, wr_ready, pix_valid_o, pix_transp_o,
         swap_pending} !== 5'b10000) begin
      n_fail++;
      $display("FAIL rst.flags got %b want 10000",
               {init_busy, wr_ready, pix_valid_o,
                pix_transp_o, swap_pending});
    end
    n_chk++;
    if ({red, green, blue} !== DEF) begin
      n_fail++;
      $display("FAIL rst.color got %h want %h",
               {red, green, blue}, DEF);
    end
    rst_n = 1'b1;
    cnt = 0; wrbad = 0;
    while (init_busy === 1'b1 && cnt < 100) begin
      if (wr_ready !== 1'b0) wrbad++;
      pix_valid_i = (cnt == 2); pix_index_i = 5'd20;
      cnt++;
      tick();
      if (pix_valid_o) begin
        n_chk++;
        e = exq.size() > 0 ? exq.pop_front() : 13'h1fff;
        if ({pix_transp_o, red, green, blue} !== e) begin
          n_fail++;
          $display("FAIL rst.init_lookup got %h want %h",
                   {pix_transp_o, red, green, blue}, e);
        end
      end
    end
    pix_valid_i = 1'b0;
    n_chk++;
    if (cnt != 32) begin
      n_fail++;
      $display("FAIL rst.busy_cycles got %0d want 32", cnt);
    end
    n_chk++;
    if (wrbad != 0 || wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst.wr_ready got bad=%0d rdy=%b want 0/1",
               wrbad, wr_ready);
    end
    n_chk++;
    if (exq.size() != 0) begin
      n_fail++;
      $display("FAIL rst.init_lookup_lost got %0d want 0",
               exq.size());
      exq.delete();
    end
  endtask

  task automatic test_init_lookup();
    logic [12:0] e;
    pix_valid_i = 1'b1; pix_index_i = 5'd7;
    tick();
    pix_valid_i = 1'b0;
    n_chk++;
    if (pix_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL lat.n1 got %b want 0", pix_valid_o);
    end
    tick();
    n_chk++;
    if (pix_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL lat.n2 got %b want 0", pix_valid_o);
    end
    tick();
    n_chk++;
    e = exq.size() > 0 ? exq.pop_front() : 13'h1fff;
    if (pix_valid_o !== 1'b1 ||
        {pix_transp_o, red, green, blue} !== e) begin
      n_fail++;
      $display("FAIL lat.idx7 got v=%b %h want v=1 %h", pix_valid_o,
               {pix_transp_o, red, green, blue}, e);
    end
    tick();
    n_chk++;
    if (pix_valid_o !== 1'b0 || {red, green, blue} !== e[11:0]) begin
      n_fail++;
      $display("FAIL lat.hold got v=%b %h want v=0 %h",
               pix_valid_o, {red, green, blue}, e[11:0]);
    end
    exq.delete();
  endtask

  task automatic test_swap();
    stim_t sq[$];
    stim_t idle;
    logic [12:0] e;
    idle = mk(0, 0, 0, 0, 0, 0, 0);
    sq.push_back(mk(0, 0, 1, 3, 12'hF00, 0, 0));
    sq.push_back(mk(0, 0, 0, 0, 0, 1, 0));
    sq.push_back(mk(1, 3, 0, 0, 0, 0, 0));
    sq.push_back(idle);
    sq.push_back(mk(0, 0, 0, 0, 0, 0, 1));
    sq.push_back(mk(1, 3, 0, 0, 0, 0, 0));
    for (int c = 0; c < sq.size() + 4; c++) begin
      drive(c < sq.size() ? sq[c] : idle);
      tick();
      n_chk++;
      if (swap_pending !== mpend) begin
        n_fail++;
        $display("FAIL swap.pending c%0d got %b want %b",
                 c, swap_pending, mpend);
      end
      if (pix_valid_o) begin
        n_chk++;
        e = exq.size() > 0 ? exq.pop_front() : 13'h1fff;
        if ({pix_transp_o, red, green, blue} !== e ||
            {pix_transp2, red2, green2, blue2} !== {1'b0, e[11:0]}) begin
          n_fail++;
          $display("FAIL swap.lookup c%0d got %h/%h want %h", c,
                   {pix_transp_o, red, green, blue},
                   {pix_transp2, red2, green2, blue2}, e);
        end
      end
    end
    n_chk++;
    if (exq.size() != 0) begin
      n_fail++;
      $display("FAIL swap.timeout got %0d left want 0", exq.size());
      exq.delete();
    end
  endtask

  task automatic test_swap_same_cycle();
    stim_t sq[$];
    stim_t idle;
    logic [12:0] e;
    idle = mk(0, 0, 0, 0, 0, 0, 0);
    sq.push_back(mk(0, 0, 0, 0, 0, 1, 1));
    sq.push_back(mk(1, 3, 0, 0, 0, 0, 0));
    sq.push_back(mk(0, 0, 0, 0, 0, 0, 1));
    sq.push_back(mk(1, 3, 0, 0, 0, 0, 0));
    for (int c = 0; c < sq.size() + 4; c++) begin
      drive(c < sq.size() ? sq[c] : idle);
      tick();
      n_chk++;
      if (swap_pending !== mpend) begin
        n_fail++;
        $display("FAIL same.pending c%0d got %b want %b",
                 c, swap_pending, mpend);
      end
      if (pix_valid_o) begin
        n_chk++;
        e = exq.size() > 0 ? exq.pop_front() : 13'h1fff;
        if ({pix_transp_o, red, green, blue} !== e) begin
          n_fail++;
          $display("FAIL same.lookup c%0d got %h want %h", c,
                   {pix_transp_o, red, green, blue}, e);
        end
      end
    end
    n_chk++;
    if (exq.size() != 0) begin
      n_fail++;
      $display("FAIL same.timeout got %0d left want 0", exq.size());
      exq.delete();
    end
  endtask

  task automatic test_transp();
    stim_t sq[$];
    stim_t idle;
    logic [12:0] e;
    idle = mk(0, 0, 0, 0, 0, 0, 0);
    sq.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    sq.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    sq.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    sq.push_back(mk(1, 31, 0, 0, 0, 0, 0));
    for (int c = 0; c < sq.size() + 4; c++) begin
      drive(c < sq.size() ? sq[c] : idle);
      tick();
      if (pix_valid_o) begin
        n_chk++;
        e = exq.size() > 0 ? exq.pop_front() : 13'h1fff;
        if ({pix_transp_o, red, green, blue} !== e ||
            {pix_transp2, red2, green2, blue2} !== {1'b0, e[11:0]}) begin
          n_fail++;
          $display("FAIL transp.lookup c%0d got %h/%h want %h", c,
                   {pix_transp_o, red, green, blue},
                   {pix_transp2, red2, green2, blue2}, e);
        end
      end
    end
    n_chk++;
    if (exq.size() != 0) begin
      n_fail++;
      $display("FAIL transp.timeout got %0d left want 0", exq.size());
      exq.delete();
    end
  endtask

  task automatic test_back_to_back();
    stim_t sq[$];
    stim_t idle;
    logic [12:0] e;
    idle = mk(0, 0, 0, 0, 0, 0, 0);
    sq.push_back(mk(1, 3, 1, 5, 12'h123, 1, 0));
    sq.push_back(mk(1, 5, 0, 0, 0, 0, 0));
    sq.push_back(mk(1, 5, 1, 6, 12'hABC, 0, 1));
    sq.push_back(mk(1, 6, 0, 0, 0, 0, 0));
    sq.push_back(mk(1, 3, 0, 0, 0, 0, 0));
    sq.push_back(mk(1, 3, 1, 3, 12'h0F0, 0, 0));
    sq.push_back(mk(0, 0, 0, 0, 0, 1, 0));
    sq.push_back(mk(0, 0, 0, 0, 0, 1, 0));
    sq.push_back(mk(1, 3, 0, 0, 0, 0, 1));
    sq.push_back(mk(1, 3, 0, 0, 0, 0, 1));
    sq.push_back(mk(1, 5, 0, 0, 0, 0, 0));
    sq.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    for (int c = 0; c < sq.size() + 4; c++) begin
      drive(c < sq.size() ? sq[c] : idle);
      tick();
      n_chk++;
      if (swap_pending !== mpend) begin
        n_fail++;
        $display("FAIL b2b.pending c%0d got %b want %b",
                 c, swap_pending, mpend);
      end
      if (pix_valid_o) begin
        n_chk++;
        e = exq.size() > 0 ? exq.pop_front() : 13'h1fff;
        if ({pix_transp_o, red, green, blue} !== e) begin
          n_fail++;
          $display("FAIL b2b.lookup c%0d got %h want %h", c,
                   {pix_transp_o, red, green, blue}, e);
        end
      end
    end
    n_chk++;
    if (exq.size() != 0) begin
      n_fail++;
      $display("FAIL b2b.timeout got %0d left want 0", exq.size());
      exq.delete();
    end
  endtask

  task automatic test_reset_mid_init();
    int cnt, stray;
    logic [12:0] e;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    repeat (3) tick();
    pix_valid_i = 1'b1; pix_index_i = 5'd9;
    tick();
    pix_valid_i = 1'b0;
    n_chk++;
    if (swap_pending !== mpend || init_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid.before got p=%b b=%b want p=%b b=1",
               swap_pending, init_busy, mpend);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_chk++;
    if (swap_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL mid.pending got %b want 0", swap_pending);
    end
    cnt = 0; stray = 0;
    while (init_busy === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
      if (pix_valid_o) stray++;
    end
    n_chk++;
    if (cnt != 32) begin
      n_fail++;
      $display("FAIL mid.busy_cycles got %0d want 32", cnt);
    end
    n_chk++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL mid.discard got %0d outputs want 0", stray);
    end
    pix_valid_i = 1'b1; pix_index_i = 5'd3;
    tick();
    pix_valid_i = 1'b0;
    repeat (2) tick();
    n_chk++;
    e = exq.size() > 0 ? exq.pop_front() : 13'h1fff;
    if (pix_valid_o !== 1'b1 ||
        {pix_transp_o, red, green, blue} !== e) begin
      n_fail++;
      $display("FAIL mid.reinit got v=%b %h want v=1 %h", pix_valid_o,
               {pix_transp_o, red, green, blue}, e);
    end
    exq.delete();
  endtask

  initial begin
    test_reset();
    test_init_lookup();
    test_swap();
    test_swap_same_cycle();
    test_transp();
    test_back_to_back();
    test_reset_mid_init();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
